// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Register bank with two read ports, one writeback port and a per-register
//   busy scoreboard. Decode reads operands and reserves a destination.
//   Writeback writes the result and releases the reservation.
//
//   Ports
//     clk, reset             clock; synchronous active-high reset
//     rd_addr1/2             read port addresses
//     rd_data1/2             read data (write-to-read bypass, optional zero reg)
//     rd_busy1/2             addressed register still waits on a producer
//     wr_en/wr_addr/wr_data  writeback; writing also releases the busy bit
//     rsv_en/rsv_addr        reserve a destination (sets its busy bit)
//     busy_count             number of busy registers after the last edge
//
//   READ_REG=0 gives combinational read ports. READ_REG=1 registers
//   rd_data/rd_busy, which adds one cycle of latency.

module regfile_scoreboard_rdport #(
  parameter int WIDTH    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int READ_REG = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [AW-1:0]    i_rd_addr,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [WIDTH-1:0] i_mem_data,
  input  logic             i_mem_busy,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_rd_busy
);
  logic             w_hit, w_zero, w_busy;
  logic [WIDTH-1:0] w_data;
  logic             w_unused;

  // In the combinational variant the clock and reset are not used.
  assign w_unused = i_clk ^ i_rst;

  assign w_hit  = i_wr_en && (i_wr_addr == i_rd_addr);
  assign w_zero = (ZERO_REG != 0) && (i_rd_addr == '0);
  assign w_data = w_zero ? '0 : (w_hit ? i_wr_data : i_mem_data);
  // A result that arrives this cycle counts as available.
  assign w_busy = i_mem_busy && !w_hit;

  if (READ_REG != 0) begin : g_reg
    logic [WIDTH-1:0] r_data;
    logic             r_busy;
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_data <= '0;
        r_busy <= 1'b0;
      end else begin
        r_data <= w_data;
        r_busy <= w_busy;
      end
    end
    assign o_rd_data = r_data;
    assign o_rd_busy = r_busy;
  end else begin : g_comb
    assign o_rd_data = w_data;
    assign o_rd_busy = w_busy;
  end
endmodule

module regfile_scoreboard #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = $clog2(DEPTH),
  parameter int ZERO_REG = 1,
  parameter int READ_REG = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    rd_addr1,
  input  logic [AW-1:0]    rd_addr2,
  output logic [WIDTH-1:0] rd_data1,
  output logic [WIDTH-1:0] rd_data2,
  output logic             rd_busy1,
  output logic             rd_busy2,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  output logic [AW:0]      busy_count
);
  localparam int NUM_RP = 2;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_busy;
  logic [AW:0]      r_busy_count;

  logic [DEPTH-1:0]             w_busy_nxt;
  logic [AW:0]                  w_busy_cnt_nxt;
  logic                         w_wr_ok;
  logic [NUM_RP-1:0][AW-1:0]    w_rd_addr;
  logic [NUM_RP-1:0][WIDTH-1:0] w_mem_rd, w_rd_data;
  logic [NUM_RP-1:0]            w_mem_busy, w_rd_busy;

  // Register 0 swallows writes when it is hardwired to zero.
  assign w_wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

  // A reserve overrides a release on the same register: the new producer wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (wr_en)  w_busy_nxt[wr_addr]  = 1'b0;
    if (rsv_en) w_busy_nxt[rsv_addr] = 1'b1;
    if (ZERO_REG != 0) w_busy_nxt[0] = 1'b0;
  end

  // busy_count tracks the post-update vector so it lines up with r_busy.
  always_comb begin
    w_busy_cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++)
      w_busy_cnt_nxt = w_busy_cnt_nxt + (AW+1)'(w_busy_nxt[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_busy       <= '0;
      r_busy_count <= '0;
    end else begin
      if (w_wr_ok) r_mem[wr_addr] <= wr_data;
      r_busy       <= w_busy_nxt;
      r_busy_count <= w_busy_cnt_nxt;
    end
  end

  assign w_rd_addr[0] = rd_addr1;
  assign w_rd_addr[1] = rd_addr2;

  for (genvar p = 0; p < NUM_RP; p++) begin : g_rp
    assign w_mem_rd[p]   = r_mem[w_rd_addr[p]];
    assign w_mem_busy[p] = r_busy[w_rd_addr[p]];

    regfile_scoreboard_rdport #(
      .WIDTH(WIDTH), .AW(AW), .ZERO_REG(ZERO_REG), .READ_REG(READ_REG)
    ) u_rp (
      .i_clk      (clk),
      .i_rst      (reset),
      .i_rd_addr  (w_rd_addr[p]),
      .i_wr_en    (wr_en),
      .i_wr_addr  (wr_addr),
      .i_wr_data  (wr_data),
      .i_mem_data (w_mem_rd[p]),
      .i_mem_busy (w_mem_busy[p]),
      .o_rd_data  (w_rd_data[p]),
      .o_rd_busy  (w_rd_busy[p])
    );
  end

  assign rd_data1   = w_rd_data[0];
  assign rd_data2   = w_rd_data[1];
  assign rd_busy1   = w_rd_busy[0];
  assign rd_busy2   = w_rd_busy[1];
  assign busy_count = r_busy_count;
endmodule
